// File: rtl/float_norm_pack.sv
// Float adder back end: normalizes a carry-extended mantissa sum one shift per
// cycle, then packs an IEEE-754 single-precision word with overflow/underflow flags.
module float_norm_pack #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    sign_in,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic [FRAC_W+1:0]       mant_in,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned MANT_W = FRAC_W + 2;
  localparam int unsigned IE_W   = EXP_W + 1;
  localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;

  localparam logic [IE_W-1:0] EXP_MAX = IE_W'((1 << EXP_W) - 1);
  localparam logic [IE_W-1:0] EXP_ONE = IE_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHR,
    SHL,
    PACK,
    INF,
    ZERO,
    UFL
  } state_t;

  state_t              state;
  logic                sign_q;
  logic [IE_W-1:0]     exp_q;
  logic [MANT_W-1:0]   mant_q;
  logic [IE_W-1:0]     exp_inc;

  // One extra exponent bit so a carry increment past the field is visible.
  assign exp_inc = exp_q + IE_W'(1);

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q    <= sign_in;
            exp_q     <= {1'b0, exp_in};
            mant_q    <= mant_in;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            state     <= CHECK;
          end
        end

        CHECK: begin
          if (exp_q == EXP_MAX)           state <= INF;
          else if (mant_q == '0)          state <= ZERO;
          else if (mant_q[MANT_W-1])      state <= SHR;
          else if (mant_q[FRAC_W])        state <= PACK;
          else                            state <= SHL;
        end

        // Carry out of the adder: a single right shift, dropped bit truncated.
        SHR: begin
          mant_q <= mant_q >> 1;
          exp_q  <= exp_inc;
          state  <= (exp_inc == EXP_MAX) ? INF : PACK;
        end

        // Left shifts stop before the exponent would reach zero (no denormals).
        SHL: begin
          if (exp_q <= EXP_ONE) begin
            state <= UFL;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - IE_W'(1);
            state  <= mant_q[FRAC_W-1] ? PACK : SHL;
          end
        end

        PACK: begin
          result <= {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        INF: begin
          result   <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          overflow <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        ZERO: begin
          result <= {sign_q, (RES_W-1)'(0)};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        UFL: begin
          result    <= {sign_q, (RES_W-1)'(0)};
          underflow <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_norm_pack.sv
// Directed bench for float_norm_pack: latency, packed result, flags and handshake.
module tb_float_norm_pack;

  logic        clk;
  logic        res;
  logic        start;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  float_norm_pack dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges until done is seen high; 0 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  // Present a job and return just after the accept edge E0.
  task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m);
    start = 1'b1; sign_in = s; exp_in = e; mant_in = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, result, overflow, underflow} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h ovf=%b ufl=%b, want all 0",
               busy, done, result, overflow, underflow);
    end
    res = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_job(input string name, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input int exp_n, input logic [31:0] exp_r,
                          input logic exp_o, input logic exp_u);
    int n;
    issue(s, e, m);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, want 1", name, busy);
    end
    wait_done(n);
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s_latency: got %0d, want %0d", name, n, exp_n);
    end
    checks++;
    if (result !== exp_r || overflow !== exp_o || underflow !== exp_u || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got %h ovf=%b ufl=%b busy=%b, want %h ovf=%b ufl=%b busy=0",
               name, result, overflow, underflow, busy, exp_r, exp_o, exp_u);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== exp_r) begin
      errors++;
      $display("FAIL %s_hold: got done=%b result=%h, want done=0 result=%h",
               name, done, result, exp_r);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(1'b0, 8'd127, 25'h0000001);
    repeat (4) begin @(posedge clk); #1; end
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    checks++;
    if ({busy, done, result, overflow, underflow} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b result=%h ovf=%b ufl=%b, want all 0",
               busy, done, result, overflow, underflow);
    end
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", pulses);
    end
  endtask

  task automatic test_start_busy();
    int n;
    int pulses;
    // 4 left shifts: done at E6.
    issue(1'b0, 8'd127, 25'h0080000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; sign_in = 1'b1; exp_in = 8'd255; mant_in = 25'h1FFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d edges after E3, want 3", n);
    end
    checks++;
    if (result !== 32'h3D800000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_result: got %h ovf=%b, want 3d800000 ovf=0", result, overflow);
    end
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL busy_start_dropped: got %0d active cycles, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(1'b0, 8'd254, 25'h1800000);
    wait_done(n);
    checks++;
    if (n !== 3 || result !== 32'h7F800000 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got n=%0d result=%h ovf=%b, want n=3 7f800000 ovf=1",
               n, result, overflow);
    end
    // Start presented during the done cycle.
    issue(1'b0, 8'd127, 25'h1800000);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", done, busy);
    end
    wait_done(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, want 3", n);
    end
    checks++;
    if (result !== 32'h40400000 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got %h ovf=%b ufl=%b, want 40400000 ovf=0 ufl=0",
               result, overflow, underflow);
    end
  endtask

  initial begin
    res = 1'b0; start = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
    #2;
    test_reset();
    test_job("normalized", 1'b0, 8'd127, 25'h0800000, 2, 32'h3F800000, 1'b0, 1'b0);
    test_job("carry",      1'b0, 8'd127, 25'h1000000, 3, 32'h40000000, 1'b0, 1'b0);
    test_job("left1",      1'b1, 8'd127, 25'h0400000, 3, 32'hBF000000, 1'b0, 1'b0);
    test_job("overflow",   1'b0, 8'd254, 25'h1800000, 3, 32'h7F800000, 1'b1, 1'b0);
    test_job("underflow",  1'b1, 8'd5,   25'h0000001, 7, 32'h80000000, 1'b0, 1'b1);
    test_job("zero",       1'b1, 8'd100, 25'h0000000, 2, 32'h80000000, 1'b0, 1'b0);
    test_job("exp_inf",    1'b1, 8'd255, 25'h0812345, 2, 32'hFF800000, 1'b1, 1'b0);
    test_job("left23",     1'b0, 8'd127, 25'h0000001, 25, 32'h34000000, 1'b0, 1'b0);
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
